// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver and scancode framer.
// Synchronises and filters the raw PS/2 lines, frames 11-bit serial words,
// strips E0/F0/E1 prefixes, tracks Shift and emits one strobe per key event.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity enforced when defined).
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       e0,
    output logic       shift,
    output logic       key_down,
    output logic       key_up,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchroniser and filter state
    logic          clk_meta, clk_sync;
    logic          data_meta, data_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          fall;

    // Frame state
    state_t        state, next_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          par_ok;
    logic          deliver;
    logic          reject;

    // Prefix and shift state
    logic          e0_pend, f0_pend;
    logic [2:0]    skip_cnt;
    logic          lshift, rshift;

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Glitch filter: flip the filtered clock after FILTER_LEN cycles at the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                filt_clk <= clk_sync;
                fall     <= filt_clk;   // a 1 -> 0 transition is a falling edge
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    // Odd parity across data and parity bit.
    assign par_ok = ^{shreg, par_bit};
`else
    assign par_ok = 1'b1;
`endif

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Frame FSM next-state and delivery decode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        next_state = state;
        deliver    = 1'b0;
        reject     = 1'b0;
        timeout    = !fall && (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE:   if (fall && !data_sync) next_state = DATA;
            DATA:   if (fall && bit_cnt == 3'd7) next_state = PARITY;
            PARITY: if (fall) next_state = STOP;
            STOP: begin
                if (fall) begin
                    next_state = IDLE;
                    if (data_sync && par_ok) deliver = 1'b1;
                    else                     reject  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (timeout) next_state = IDLE;
    end

    // Frame datapath: bit counter, shift register, parity capture, idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (fall || state == IDLE) to_cnt <= '0;
            else                       to_cnt <= to_cnt + TW'(1);
            if (fall) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {data_sync, shreg[7:1]};   // LSB arrives first
                        bit_cnt <= bit_cnt + 3'd1;
                    end
`ifdef PS2_PARITY_CHECK_EN
                    PARITY: par_bit <= data_sync;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Prefix stripping, shift tracking and event strobes per delivered byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            scancode  <= '0;
            e0        <= 1'b0;
            key_down  <= 1'b0;
            key_up    <= 1'b0;
            frame_err <= 1'b0;
            e0_pend   <= 1'b0;
            f0_pend   <= 1'b0;
            skip_cnt  <= '0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
        end else begin
            key_down  <= 1'b0;
            key_up    <= 1'b0;
            frame_err <= reject;
            if (deliver) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;    // swallowing the Pause sequence
                end else begin
                    case (shreg)
                        8'hE0: e0_pend  <= 1'b1;
                        8'hF0: f0_pend  <= 1'b1;
                        8'hE1: skip_cnt <= 3'd7;
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            scancode <= shreg;
                            e0       <= e0_pend;
                            key_up   <= f0_pend;
                            key_down <= !f0_pend;
                            e0_pend  <= 1'b0;
                            f0_pend  <= 1'b0;
                            // E0-prefixed 12 is a fake shift and leaves state alone
                            if (!e0_pend && shreg == 8'h12) lshift <= !f0_pend;
                            if (!e0_pend && shreg == 8'h59) rshift <= !f0_pend;
                        end
                    endcase
                end
            end
        end
    end

    assign shift = lshift | rshift;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: directed scenarios plus randomized key traffic,
// checked against a byte-level behavioural model of the keyboard protocol.
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1500;
    localparam int HALF       = 15;   // PS/2 half-period in system clocks

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       e0;
    logic       shift;
    logic       key_down;
    logic       key_up;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_DOWN, EV_UP, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] code;
        logic       e0;
        logic       shift;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state (keyboard protocol at byte level)
    logic m_e0, m_f0, m_lsh, m_rsh;
    int   m_skip;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .scancode (scancode),
        .e0       (e0),
        .shift    (shift),
        .key_down (key_down),
        .key_up   (key_up),
        .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_e0 = 1'b0; m_f0 = 1'b0; m_lsh = 1'b0; m_rsh = 1'b0; m_skip = 0;
    endtask

    // Byte-level protocol model: what the keyboard stream means.
    task automatic model_frame(input logic [7:0] b, input logic ok);
        ev_t e;
        if (!ok) begin
            e.kind = EV_ERR; e.code = 8'h00; e.e0 = 1'b0; e.shift = 1'b0;
            exp_q.push_back(e);
            return;
        end
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        case (b)
            8'hE0: m_e0 = 1'b1;
            8'hF0: m_f0 = 1'b1;
            8'hE1: m_skip = 7;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
                if (!m_e0 && b == 8'h12) m_lsh = !m_f0;
                if (!m_e0 && b == 8'h59) m_rsh = !m_f0;
                e.kind  = m_f0 ? EV_UP : EV_DOWN;
                e.code  = b;
                e.e0    = m_e0;
                e.shift = m_lsh | m_rsh;
                exp_q.push_back(e);
                m_e0 = 1'b0;
                m_f0 = 1'b0;
            end
        endcase
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic ok;
`ifdef PS2_PARITY_CHECK_EN
        ok = !bad_stop && !bad_par;
`else
        ok = !bad_stop;
`endif
        model_frame(b, ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(!bad_stop);
        ps2_data = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    // Event monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        if (key_down || key_up || frame_err) begin
            check("strobe_exclusive", 32'(key_down & key_up), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, key_down, key_up, frame_err}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("key_down", 32'(key_down), 32'(e.kind == EV_DOWN));
                check("key_up", 32'(key_up), 32'(e.kind == EV_UP));
                check("frame_err", 32'(frame_err), 32'(e.kind == EV_ERR));
                if (e.kind != EV_ERR) begin
                    check("scancode", 32'(scancode), 32'(e.code));
                    check("e0", 32'(e0), 32'(e.e0));
                    check("shift", 32'(shift), 32'(e.shift));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_scancode"}, 32'(scancode), 32'd0);
        check({tag, "_e0"}, 32'(e0), 32'd0);
        check({tag, "_shift"}, 32'(shift), 32'd0);
        check({tag, "_key_down"}, 32'(key_down), 32'd0);
        check({tag, "_key_up"}, 32'(key_up), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        logic [7:0] c;
        int r;
        model_reset();
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        check_all_zero("reset");
        reset = 1'b0;
        wait_clk(20);

        // Single make code
        send_byte(8'h1C);

        // Shifted typing
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);

        // Extended keys and fake shift
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);

        // Inverted parity bit, then bad stop bit
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1);

        // Stall mid-frame past the timeout, then a clean frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clk(TIMEOUT + 100);
        send_byte(8'h29);

        // Short clock glitches with data low must not start a frame
        ps2_data = 1'b0;
        wait_clk(10);
        ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1;
        wait_clk(20);
        ps2_data = 1'b1;
        wait_clk(20);
        send_byte(8'h4B);

        // Pause sequence swallowed, then a normal key
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77);
        send_byte(8'hE1); send_byte(8'hF0); send_byte(8'h14);
        send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'h1C);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: begin
                    c = 8'($urandom_range(1, 127));
                    if ($urandom_range(0, 1) == 1) send_byte(8'hE0);
                    if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
                    send_byte(c);
                end
                4: begin
                    if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
                    send_byte(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
                end
                5: begin
                    case ($urandom_range(0, 5))
                        0: send_byte(8'hAA);
                        1: send_byte(8'hFA);
                        2: send_byte(8'hEE);
                        3: send_byte(8'hFE);
                        4: send_byte(8'h00);
                        default: send_byte(8'hFF);
                    endcase
                end
                6: send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                7: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
                8: send_byte(8'($urandom_range(0, 255)));
                default: begin
                    send_byte(8'hE1);
                    for (int k = 0; k < 7; k++) send_byte(8'($urandom_range(0, 255)));
                end
            endcase
        end

        // Clear any leftover skip state from random bytes before the reset test
        for (int k = 0; k < 8; k++) send_byte(8'hAA);

        // Reset mid-frame with shift held and a pending E0
        send_byte(8'h12);
        send_byte(8'hE0);
        check("pre_reset_shift", 32'(shift), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        wait_clk(1);
        check_all_zero("mid_reset");
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        wait_clk(50);
        send_byte(8'h1C);

        wait_clk(200);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
